// File: rtl/icache_refill_ctrl.sv
// Purpose : refills one 128-bit ICache line as four single-word bus reads.
// Latency : request in cycle 0, mem_ready_o in cycle 9 at best; each bus gnt/rvalid stall adds one cycle.
// Backpressure: one bus read in flight at a time; new refill requests are dropped while busy_o is high.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   icache_valid_req_i/addr_i   refill request pulse and line address
//   mem_ready_o/mem_data_o      completed-line pulse and assembled line (held between completions)
//   bus_req_o/addr_o/gnt_i      single-word read request handshake
//   bus_rvalid_i/rdata_i        read data return
//   busy_o, err_o               refill in progress; line aborted on timeout
// Build option: define ICACHE_REFILL_CRITICAL_WORD_FIRST_EN to start the burst at the requested word.
module icache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_valid_req_i,
  input  logic [31:0]  icache_addr_i,
  output logic         mem_ready_o,
  output logic [127:0] mem_data_o,
  output logic         bus_req_o,
  output logic [31:0]  bus_addr_o,
  input  logic         bus_gnt_i,
  input  logic         bus_rvalid_i,
  input  logic [31:0]  bus_rdata_i,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Counter value held during the last WAIT cycle allowed for one beat.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t         state_q, state_d;
  logic [27:0]    line_base_q;
  logic [1:0]     word_idx_q;
  logic [2:0]     beat_cnt_q;
  logic [7:0]     wait_cnt_q;
  logic [127:0]   line_buf_q;
  logic [127:0]   data_hold_q;
  logic           err_q;
  logic [1:0]     start_idx;
  logic           timeout;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = icache_addr_i[3:2];
  logic [1:0] addr_lo_unused;
  assign addr_lo_unused = icache_addr_i[1:0];
`else
  assign start_idx = 2'd0;
  logic [3:0] addr_lo_unused;
  assign addr_lo_unused = icache_addr_i[3:0];
`endif

  // Abort only when the last allowed WAIT cycle also passes without data;
  // data arriving in that same cycle is still accepted.
  assign timeout = (state_q == WAIT) && !bus_rvalid_i && (wait_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (icache_valid_req_i) state_d = REQ;
      REQ:  if (bus_gnt_i) state_d = WAIT;
      WAIT: begin
        if (bus_rvalid_i)  state_d = (beat_cnt_q == 3'd3) ? DONE : REQ;
        else if (timeout)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: address/beat tracking and line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base_q <= '0;
      word_idx_q  <= '0;
      beat_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      line_buf_q  <= '0;
      data_hold_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (icache_valid_req_i) begin
            line_base_q <= icache_addr_i[31:4];
            word_idx_q  <= start_idx;
            beat_cnt_q  <= '0;
            line_buf_q  <= '0;
            err_q       <= 1'b0;
          end
        end
        REQ: begin
          if (bus_gnt_i) wait_cnt_q <= '0;
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            // Slot chosen by address, so wrapped bursts land in place.
            line_buf_q[{word_idx_q, 5'd0} +: 32] <= bus_rdata_i;
            beat_cnt_q <= beat_cnt_q + 3'd1;
            word_idx_q <= word_idx_q + 2'd1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            err_q      <= timeout;
          end
        end
        DONE: data_hold_q <= line_buf_q;
        default: ;
      endcase
    end
  end

  // Outputs. The line buffer is cleared on each new request, so a separate
  // copy keeps mem_data_o stable between completions.
  always_comb begin
    busy_o      = (state_q != IDLE);
    bus_req_o   = (state_q == REQ);
    bus_addr_o  = (state_q == REQ) ? {line_base_q, word_idx_q, 2'b00} : 32'd0;
    mem_ready_o = (state_q == DONE);
    err_o       = (state_q == DONE) && err_q;
    mem_data_o  = (state_q == DONE) ? line_buf_q : data_hold_q;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum number of WAIT cycles per beat before abort (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port icache_valid_req_i, input, 1 bit: single-cycle line-refill request pulse from the ICache.
REQ-005 The block SHALL have port icache_addr_i, input, 32 bits: refill address. Bits [31:4] are the line base; bits [3:2] are the requested word.
REQ-006 The block SHALL have port mem_ready_o, output, 1 bit: one-cycle pulse indicating that mem_data_o holds a completed line.
REQ-007 The block SHALL have port mem_data_o, output, 128 bits: the assembled line, with word k at bits [32k+31:32k].
REQ-008 The block SHALL have port bus_req_o, output, 1 bit: single-word read request to the memory bus.
REQ-009 The block SHALL have port bus_addr_o, output, 32 bits: word-aligned bus read address.
REQ-010 The block SHALL have port bus_gnt_i, input, 1 bit: the bus accepts the current request.
REQ-011 The block SHALL have port bus_rvalid_i, input, 1 bit: read data valid.
REQ-012 The block SHALL have port bus_rdata_i, input, 32 bits: read data.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port err_o, output, 1 bit: one-cycle pulse, coincident with mem_ready_o, when a refill aborted on timeout.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and DONE.
REQ-016 In IDLE, the block SHALL, when icache_valid_req_i=1, latch icache_addr_i[31:4], set the starting word index, clear the line buffer and beat count, and go to REQ.
REQ-017 In REQ, bus_req_o SHALL be 1 and bus_addr_o SHALL equal {line_base, word_idx, 2'b00}. Both SHALL stay stable until bus_gnt_i=1, after which the FSM goes to WAIT.
REQ-018 In WAIT, on bus_rvalid_i=1 the block SHALL write bus_rdata_i into the buffer slot word_idx and increment the beat count. word_idx SHALL increment modulo 4, wrapping 3 to 0.
REQ-019 On the 4th beat the FSM SHALL go to DONE; otherwise it SHALL go back to REQ.
REQ-020 One bus transaction SHALL be outstanding at most. bus_rvalid_i outside WAIT SHALL be ignored; bus_gnt_i outside REQ SHALL be ignored.
REQ-021 In DONE, mem_ready_o SHALL be 1 for exactly one cycle and mem_data_o SHALL present the buffer. The FSM SHALL then return to IDLE.
REQ-022 mem_data_o SHALL hold its last value until the next DONE.
REQ-023 Minimum latency (bus_gnt_i=1 in every REQ cycle, bus_rvalid_i=1 in every WAIT cycle): request sampled in cycle 0 -> REQ in cycles 1,3,5,7 -> WAIT in cycles 2,4,6,8 -> mem_ready_o=1 in cycle 9.
REQ-024 icache_valid_req_i SHALL be ignored outside IDLE (no queuing).
REQ-025 A WAIT-cycle counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYC without bus_rvalid_i, the FSM SHALL go to DONE with err_o=1. Words not yet received SHALL read as zero in mem_data_o.
REQ-026 If bus_rvalid_i arrives in the same cycle the counter reaches TIMEOUT_CYC, the data SHALL win: the beat is accepted and there is no error.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE from any state, including mid-refill, and discard the partial line.
REQ-028 Reset values SHALL be: mem_ready_o=0, mem_data_o=0, bus_req_o=0, bus_addr_o=0, busy_o=0, err_o=0, beat count and timeout counter 0.
REQ-029 A request pulsed in the same cycle as rst=1 SHALL be dropped.

Configuration
REQ-030 With macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN defined, the starting word_idx SHALL be icache_addr_i[3:2], giving beat order offset, offset+1, ... modulo 4.
REQ-031 Without ICACHE_REFILL_CRITICAL_WORD_FIRST_EN, the starting word_idx SHALL be 0 regardless of icache_addr_i[3:2], giving beat order 0,1,2,3.
REQ-032 In both builds, word placement in mem_data_o SHALL be by address, not by arrival order.

Verification
REQ-033 Request addr 0x0000_1230, gnt and rvalid always 1, rdata = 0x11,0x22,0x33,0x44 -> bus_addr_o 0x1230,0x1234,0x1238,0x123C; mem_ready_o in cycle 9; mem_data_o = 0x00000044_00000033_00000022_00000011.
REQ-034 With CRITICAL_WORD_FIRST_EN, request addr 0x0000_1238 -> bus_addr_o order 0x1238,0x123C,0x1230,0x1234; each word placed in its address slot.
REQ-035 bus_gnt_i held 0 for 5 cycles in the first REQ -> bus_req_o and bus_addr_o stable throughout; completion delayed by exactly 5 cycles versus REQ-033.
REQ-036 TIMEOUT_CYC=4, no rvalid on beat 2 -> err_o=1 and mem_ready_o=1 in the same cycle; words 1..3 of mem_data_o are zero (non-CWF build).
REQ-037 rst=1 asserted in WAIT of beat 3 -> next cycle busy_o=0 and all outputs at reset values; a new request then completes normally.
REQ-038 Second icache_valid_req_i pulse during REQ/WAIT -> ignored; exactly one mem_ready_o pulse.
